// File: rtl/scan_ptn_pkg.sv
// ---------------------------------------------------------------------------
// scan_ptn_pkg
// Shared definitions for the scan pattern engine: the controller state
// encoding and the default values of the engine's size parameters.
// ---------------------------------------------------------------------------
package scan_ptn_pkg;

  // Default number of scan chains driven in parallel (legal range 1..16).
  localparam int NCHAIN_DEF = 4;
  // Default width of the shift-length and vector counters.
  localparam int LENW_DEF   = 8;
  // Default width of the pattern counters and the miscompare counter.
  localparam int PATW_DEF   = 16;

  // Controller states. SHIFT loads a pattern while unloading the previous
  // one, CAPTURE pulses the functional clock, UNLOAD drains the last pattern.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHIFT   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_UNLOAD  = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/scan_ptn_cmp.sv
// ---------------------------------------------------------------------------
// scan_ptn_cmp
// Masked scan-out compare and result bookkeeping for the scan pattern engine.
//
// Ports
//   clk            in   block clock
//   srst           in   synchronous active-high reset
//   clr            in   clear all results (start of a new run)
//   en             in   a vector is being accepted and must be compared
//   so             in   NCHAIN  observed chain outputs
//   exp_vec        in   NCHAIN  expected chain outputs
//   msk            in   NCHAIN  compare mask, 1 = don't care
//   fail_pat       in   PATW    pattern index to report if this vector fails
//   miscmp_cnt     out  PATW    mismatching vectors, saturating at all-ones
//   first_fail_pat out  PATW    pattern index of the first mismatch
//   fail           out  1       sticky: at least one mismatch seen
// ---------------------------------------------------------------------------
module scan_ptn_cmp
  import scan_ptn_pkg::*;
#(
  parameter int NCHAIN = NCHAIN_DEF,
  parameter int PATW   = PATW_DEF
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              clr,
  input  logic              en,
  input  logic [NCHAIN-1:0] so,
  input  logic [NCHAIN-1:0] exp_vec,
  input  logic [NCHAIN-1:0] msk,
  input  logic [PATW-1:0]   fail_pat,
  output logic [PATW-1:0]   miscmp_cnt,
  output logic [PATW-1:0]   first_fail_pat,
  output logic              fail
);

  logic mismatch;
  logic hit;

  // Any unmasked chain whose output differs from the expectation fails the
  // whole vector; a vector counts once no matter how many chains differ.
  assign mismatch = |((so ^ exp_vec) & ~msk);
  assign hit      = en & mismatch;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (srst || clr) begin
      miscmp_cnt     <= '0;
      first_fail_pat <= '0;
      fail           <= 1'b0;
    end else if (hit) begin
      // Saturate instead of wrapping so a long failing run never reads clean.
      if (miscmp_cnt != '1) begin
        miscmp_cnt <= miscmp_cnt + PATW'(1);
      end
      // Only the first mismatch of a run is recorded.
      if (!fail) begin
        first_fail_pat <= fail_pat;
      end
      fail <= 1'b1;
    end
  end

endmodule

// File: rtl/scan_ptn_engine.sv
// ---------------------------------------------------------------------------
// scan_ptn_engine
// Streams scan vectors into NCHAIN parallel scan chains, pulses capture
// clocks between patterns and compares the unloaded response against
// expected data with a per-chain mask. Pattern n+1 is shifted in while the
// response of pattern n is shifted out; a final UNLOAD pass drains the last
// response, so one run consumes (cfg_npat+1)*cfg_len vectors.
//
// Ports
//   clk, srst                       clock, synchronous active-high reset
//   start, abort                    run request / immediate termination
//   cfg_len  [LENW]                 vectors per load/unload
//   cfg_npat [PATW]                 number of patterns
//   cfg_cap  [2]                    capture pulses minus one
//   vec_valid / vec_ready           vector stream handshake
//   vec_si, vec_exp, vec_msk        scan-in, expected scan-out, mask
//   scan_en, scan_clk_en            chain control
//   scan_si / scan_so [NCHAIN]      chain inputs / chain outputs
//   busy, done, fail                run status
//   pattern_number, vector_number   current position in the run
//   miscmp_cnt, first_fail_pat      compare results
// ---------------------------------------------------------------------------
module scan_ptn_engine
  import scan_ptn_pkg::*;
#(
  parameter int NCHAIN = NCHAIN_DEF,
  parameter int LENW   = LENW_DEF,
  parameter int PATW   = PATW_DEF
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              start,
  input  logic              abort,
  input  logic [LENW-1:0]   cfg_len,
  input  logic [PATW-1:0]   cfg_npat,
  input  logic [1:0]        cfg_cap,
  input  logic              vec_valid,
  output logic              vec_ready,
  input  logic [NCHAIN-1:0] vec_si,
  input  logic [NCHAIN-1:0] vec_exp,
  input  logic [NCHAIN-1:0] vec_msk,
  output logic              scan_en,
  output logic              scan_clk_en,
  output logic [NCHAIN-1:0] scan_si,
  input  logic [NCHAIN-1:0] scan_so,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [PATW-1:0]   pattern_number,
  output logic [LENW-1:0]   vector_number,
  output logic [PATW-1:0]   miscmp_cnt,
  output logic [PATW-1:0]   first_fail_pat
);

  state_t          state;
  state_t          state_nxt;
  logic [1:0]      cap_cnt;
  logic            streaming;
  logic            accept;
  logic            last_vec;
  logic            cap_last;
  logic            start_ok;
  logic            cfg_ok;
  logic            cmp_en;
  logic [PATW-1:0] pat_inc;
  logic [PATW-1:0] fail_pat;

  assign streaming = (state == ST_SHIFT) || (state == ST_UNLOAD);

  // A vector presented in the abort cycle is not consumed, so counters and
  // results stay exactly where the run stopped.
  assign vec_ready = streaming & ~abort;
  assign accept    = vec_valid & vec_ready;
  assign last_vec  = accept && (vector_number == cfg_len - LENW'(1));
  assign cap_last  = (state == ST_CAPTURE) && (cap_cnt == cfg_cap);
  assign start_ok  = (state == ST_IDLE) && start && !abort;
  assign cfg_ok    = (cfg_len != '0) && (cfg_npat != '0);
  assign pat_inc   = pattern_number + PATW'(1);

  // Pattern 0 has no previous response to unload, so its load is not
  // compared. During SHIFT the data leaving the chains belongs to the
  // previous pattern; during UNLOAD it belongs to the last one.
  assign cmp_en   = accept &&
                    (((state == ST_SHIFT) && (pattern_number != '0)) ||
                     (state == ST_UNLOAD));
  assign fail_pat = (state == ST_UNLOAD) ? (cfg_npat - PATW'(1))
                                         : (pattern_number - PATW'(1));

  // NOTE: reset is synchronous, so it is sampled only inside the clocked
  // block and has no effect between edges.
  always_ff @(posedge clk) begin
    if (srst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    scan_en     = 1'b0;
    scan_clk_en = 1'b0;
    scan_si     = '0;
    busy        = (state != ST_IDLE);
    done        = 1'b0;

    if (abort && (state != ST_IDLE)) begin
      // Abort wins over any end-of-state transition in the same cycle.
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            state_nxt = cfg_ok ? ST_SHIFT : ST_DONE;
          end
        end
        ST_SHIFT: begin
          if (last_vec) begin
            state_nxt = ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (cap_last) begin
            state_nxt = (pat_inc == cfg_npat) ? ST_UNLOAD : ST_SHIFT;
          end
        end
        ST_UNLOAD: begin
          if (last_vec) begin
            state_nxt = ST_DONE;
          end
        end
        ST_DONE: begin
          state_nxt = ST_IDLE;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end

    case (state)
      ST_SHIFT, ST_UNLOAD: begin
        scan_en     = 1'b1;
        scan_clk_en = accept;
        scan_si     = vec_si;
      end
      ST_CAPTURE: begin
        scan_clk_en = 1'b1;
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Position counters. On abort nothing is accepted and CAPTURE does not
  // advance, so both counters hold their values.
  always_ff @(posedge clk) begin
    if (srst) begin
      pattern_number <= '0;
      vector_number  <= '0;
      cap_cnt        <= '0;
    end else begin
      if (start_ok) begin
        pattern_number <= '0;
        vector_number  <= '0;
      end

      if (accept) begin
        vector_number <= last_vec ? '0 : vector_number + LENW'(1);
      end

      if (state != ST_CAPTURE) begin
        cap_cnt <= '0;
      end else if (!abort) begin
        if (cap_last) begin
          cap_cnt        <= '0;
          pattern_number <= pat_inc;
        end else begin
          cap_cnt <= cap_cnt + 2'd1;
        end
      end
    end
  end

  scan_ptn_cmp #(
    .NCHAIN (NCHAIN),
    .PATW   (PATW)
  ) u_cmp (
    .clk            (clk),
    .srst           (srst),
    .clr            (start_ok),
    .en             (cmp_en),
    .so             (scan_so),
    .exp_vec        (vec_exp),
    .msk            (vec_msk),
    .fail_pat       (fail_pat),
    .miscmp_cnt     (miscmp_cnt),
    .first_fail_pat (first_fail_pat),
    .fail           (fail)
  );

endmodule

// File: tb/tb_scan_ptn_engine.sv
// ---------------------------------------------------------------------------
// tb_scan_ptn_engine
// Self-checking bench for scan_ptn_engine. Two instances share the stimulus:
// one with default sizes and one with a 4-bit pattern width to exercise the
// saturating miscompare counter. Expected results come from a run-level
// model: vector k of a run belongs to pattern k/len at position k%len, is
// compared when k/len > 0, and a failure is reported against pattern k/len-1.
// ---------------------------------------------------------------------------
module tb_scan_ptn_engine;

  localparam int NCHAIN = 4;
  localparam int LENW   = 8;
  localparam int PATW   = 16;
  localparam int TABN   = 256;

  logic              clk;
  logic              srst;
  logic              start;
  logic              abort;
  logic [LENW-1:0]   cfg_len;
  logic [PATW-1:0]   cfg_npat;
  logic [1:0]        cfg_cap;
  logic              vec_valid;
  logic              vec_ready;
  logic [NCHAIN-1:0] vec_si;
  logic [NCHAIN-1:0] vec_exp;
  logic [NCHAIN-1:0] vec_msk;
  logic              scan_en;
  logic              scan_clk_en;
  logic [NCHAIN-1:0] scan_si;
  logic [NCHAIN-1:0] scan_so;
  logic              busy;
  logic              done;
  logic              fail;
  logic [PATW-1:0]   pattern_number;
  logic [LENW-1:0]   vector_number;
  logic [PATW-1:0]   miscmp_cnt;
  logic [PATW-1:0]   first_fail_pat;

  // Narrow-counter instance signals.
  logic [3:0]        cfg_npat4;
  logic              vec_ready4;
  logic              scan_en4;
  logic              scan_clk_en4;
  logic [NCHAIN-1:0] scan_si4;
  logic              busy4;
  logic              done4;
  logic              fail4;
  logic [3:0]        pattern_number4;
  logic [LENW-1:0]   vector_number4;
  logic [3:0]        miscmp_cnt4;
  logic [3:0]        first_fail_pat4;

  assign cfg_npat4 = cfg_npat[3:0];

  scan_ptn_engine #(.NCHAIN(NCHAIN), .LENW(LENW), .PATW(PATW)) dut (
    .clk(clk), .srst(srst), .start(start), .abort(abort),
    .cfg_len(cfg_len), .cfg_npat(cfg_npat), .cfg_cap(cfg_cap),
    .vec_valid(vec_valid), .vec_ready(vec_ready),
    .vec_si(vec_si), .vec_exp(vec_exp), .vec_msk(vec_msk),
    .scan_en(scan_en), .scan_clk_en(scan_clk_en),
    .scan_si(scan_si), .scan_so(scan_so),
    .busy(busy), .done(done), .fail(fail),
    .pattern_number(pattern_number), .vector_number(vector_number),
    .miscmp_cnt(miscmp_cnt), .first_fail_pat(first_fail_pat)
  );

  scan_ptn_engine #(.NCHAIN(NCHAIN), .LENW(LENW), .PATW(4)) dut4 (
    .clk(clk), .srst(srst), .start(start), .abort(abort),
    .cfg_len(cfg_len), .cfg_npat(cfg_npat4), .cfg_cap(cfg_cap),
    .vec_valid(vec_valid), .vec_ready(vec_ready4),
    .vec_si(vec_si), .vec_exp(vec_exp), .vec_msk(vec_msk),
    .scan_en(scan_en4), .scan_clk_en(scan_clk_en4),
    .scan_si(scan_si4), .scan_so(scan_so),
    .busy(busy4), .done(done4), .fail(fail4),
    .pattern_number(pattern_number4), .vector_number(vector_number4),
    .miscmp_cnt(miscmp_cnt4), .first_fail_pat(first_fail_pat4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Per-vector stimulus tables for one run.
  logic [NCHAIN-1:0] si_tab   [TABN];
  logic [NCHAIN-1:0] exp_tab  [TABN];
  logic [NCHAIN-1:0] msk_tab  [TABN];
  logic [NCHAIN-1:0] flip_tab [TABN];
  int                gap_tab  [TABN];

  // Observations collected by drive_run.
  int n_acc, cap_cycles, cap_pulses, n_done;
  int si_bad, vn_bad, stall_cycles, stall_bad;
  bit timed_out;

  // Model results.
  int exp_mis, exp_ffp;
  bit exp_fail;

  task automatic fill_tables(input int total);
    for (int i = 0; i < total; i++) begin
      si_tab[i]   = NCHAIN'($urandom);
      exp_tab[i]  = NCHAIN'($urandom);
      msk_tab[i]  = '0;
      flip_tab[i] = '0;
      gap_tab[i]  = 0;
    end
  endtask

  // Run-level reference: which vectors are compared, which fail, and
  // which pattern the first failure is charged to.
  task automatic model(input int len, input int npat, input int patw);
    int p;
    int sat;
    exp_mis  = 0;
    exp_ffp  = 0;
    exp_fail = 1'b0;
    for (int k = 0; k < (npat + 1) * len; k++) begin
      p = k / len;
      if (p > 0 && ((flip_tab[k] & ~msk_tab[k]) != '0)) begin
        if (!exp_fail) exp_ffp = p - 1;
        exp_fail = 1'b1;
        exp_mis++;
      end
    end
    sat = (1 << patw) - 1;
    if (exp_mis > sat) exp_mis = sat;
  endtask

  // Start a run and stream the table through the handshake, recording what
  // the DUT does. Inputs change on the falling edge; outputs are sampled 1
  // time unit later, well away from the rising edge.
  task automatic drive_run(input int len, input int npat, input int cap);
    int  total, k, gap, post;
    bit  prev_cap, finished;
    total = (npat + 1) * len;
    n_acc = 0; cap_cycles = 0; cap_pulses = 0; n_done = 0;
    si_bad = 0; vn_bad = 0; stall_cycles = 0; stall_bad = 0;
    timed_out = 1'b1;
    @(negedge clk);
    cfg_len   = LENW'(len);
    cfg_npat  = PATW'(npat);
    cfg_cap   = 2'(cap);
    start     = 1'b1;
    vec_valid = 1'b0;
    @(negedge clk);
    start    = 1'b0;
    k        = 0;
    gap      = gap_tab[0];
    prev_cap = 1'b0;
    finished = 1'b0;
    post     = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (k < total && gap == 0) begin
        vec_valid = 1'b1;
        vec_si    = si_tab[k];
        vec_exp   = exp_tab[k];
        vec_msk   = msk_tab[k];
        scan_so   = exp_tab[k] ^ flip_tab[k];
      end else begin
        vec_valid = 1'b0;
        vec_si    = NCHAIN'($urandom);
        scan_so   = NCHAIN'($urandom);
      end
      #1;
      if (busy && !vec_ready && scan_clk_en && !scan_en) begin
        cap_cycles++;
        if (!prev_cap) cap_pulses++;
        if (scan_si !== '0) si_bad++;
        prev_cap = 1'b1;
      end else begin
        prev_cap = 1'b0;
      end
      if (vec_valid && vec_ready) begin
        if (scan_si !== vec_si || scan_en !== 1'b1 || scan_clk_en !== 1'b1) si_bad++;
        if (vector_number !== LENW'(k % len) || pattern_number !== PATW'(k / len)) vn_bad++;
        k++;
        if (k < total) gap = gap_tab[k];
      end else if (!vec_valid) begin
        if (gap > 0) gap--;
        if (vec_ready) begin
          stall_cycles++;
          if (scan_clk_en !== 1'b0 || vector_number !== LENW'(k % len)) stall_bad++;
        end
      end
      if (done === 1'b1) begin
        n_done++;
        finished = 1'b1;
      end
      n_acc = k;
      @(negedge clk);
      if (finished) begin
        post++;
        if (post > 3) begin
          timed_out = 1'b0;
          break;
        end
      end
    end
    vec_valid = 1'b0;
  endtask

  task automatic test_reset;
    srst = 1'b1; start = 1'b1; abort = 1'b1; vec_valid = 1'b1;
    vec_si = 4'hF; vec_exp = '0; vec_msk = '0; scan_so = 4'hF;
    cfg_len = 8'd3; cfg_npat = 16'd2; cfg_cap = 2'd0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if ({busy, done, fail} !== 3'b000) begin n_errors++; $display("FAIL reset_status: got %b exp 000", {busy, done, fail}); end
    n_checks++; if ({vec_ready, scan_en, scan_clk_en} !== 3'b000) begin n_errors++; $display("FAIL reset_ctrl: got %b exp 000", {vec_ready, scan_en, scan_clk_en}); end
    n_checks++; if (scan_si !== '0) begin n_errors++; $display("FAIL reset_scan_si: got %h exp 0", scan_si); end
    n_checks++; if ({pattern_number, vector_number, miscmp_cnt, first_fail_pat} !== '0) begin n_errors++; $display("FAIL reset_counters: got %h %h %h %h exp all 0", pattern_number, vector_number, miscmp_cnt, first_fail_pat); end
    @(negedge clk);
    srst = 1'b0; start = 1'b0; abort = 1'b0; vec_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    fill_tables(9);
    model(3, 2, PATW);
    drive_run(3, 2, 0);
    n_checks++; if (timed_out) begin n_errors++; $display("FAIL basic_timeout: run did not finish"); end
    n_checks++; if (n_acc !== 9) begin n_errors++; $display("FAIL basic_accepted: got %0d exp 9", n_acc); end
    n_checks++; if (cap_pulses !== 2 || cap_cycles !== 2) begin n_errors++; $display("FAIL basic_capture: got %0d pulses %0d cycles exp 2 2", cap_pulses, cap_cycles); end
    n_checks++; if (n_done !== 1) begin n_errors++; $display("FAIL basic_done: got %0d pulses exp 1", n_done); end
    n_checks++; if (fail !== 1'b0 || miscmp_cnt !== 16'd0) begin n_errors++; $display("FAIL basic_result: got fail=%b cnt=%0d exp 0 0", fail, miscmp_cnt); end
    n_checks++; if (si_bad !== 0 || vn_bad !== 0) begin n_errors++; $display("FAIL basic_stream: got %0d si errs %0d position errs exp 0 0", si_bad, vn_bad); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL basic_idle: got busy=%b exp 0", busy); end
  endtask

  task automatic test_mismatch(input bit masked);
    fill_tables(9);
    flip_tab[4] = 4'b0100;            // pattern-1 load, vector 1, chain 2
    if (masked) msk_tab[4] = 4'b0100;
    model(3, 2, PATW);
    drive_run(3, 2, 0);
    n_checks++; if (timed_out || n_done !== 1) begin n_errors++; $display("FAIL mm%0d_done: got %0d done pulses timeout=%b exp 1 0", masked, n_done, timed_out); end
    n_checks++; if (miscmp_cnt !== PATW'(exp_mis)) begin n_errors++; $display("FAIL mm%0d_count: got %0d exp %0d", masked, miscmp_cnt, exp_mis); end
    n_checks++; if (fail !== exp_fail) begin n_errors++; $display("FAIL mm%0d_fail: got %b exp %b", masked, fail, exp_fail); end
    n_checks++; if (first_fail_pat !== PATW'(exp_ffp)) begin n_errors++; $display("FAIL mm%0d_first: got %0d exp %0d", masked, first_fail_pat, exp_ffp); end
  endtask

  task automatic test_stall;
    fill_tables(18);
    gap_tab[9] = 5;                   // pattern 1, vector 3 of 6
    model(6, 2, PATW);
    drive_run(6, 2, 1);
    n_checks++; if (stall_cycles !== 5) begin n_errors++; $display("FAIL stall_cycles: got %0d exp 5", stall_cycles); end
    n_checks++; if (stall_bad !== 0) begin n_errors++; $display("FAIL stall_hold: got %0d bad cycles exp 0", stall_bad); end
    n_checks++; if (timed_out || n_acc !== 18 || n_done !== 1) begin n_errors++; $display("FAIL stall_complete: got %0d vectors %0d done exp 18 1", n_acc, n_done); end
    n_checks++; if (cap_cycles !== 4) begin n_errors++; $display("FAIL stall_capture: got %0d exp 4", cap_cycles); end
    n_checks++; if (fail !== 1'b0 || vn_bad !== 0) begin n_errors++; $display("FAIL stall_result: got fail=%b pos errs=%0d exp 0 0", fail, vn_bad); end
  endtask

  task automatic test_abort;
    int  cyc;
    bit  seen;
    int  dones;
    @(negedge clk);
    cfg_len = 8'd2; cfg_npat = 16'd1; cfg_cap = 2'd3;
    start = 1'b1; vec_valid = 1'b0;
    @(negedge clk);
    start = 1'b0; vec_valid = 1'b1; vec_si = 4'h5; vec_exp = '0; vec_msk = '0; scan_so = '0;
    seen = 1'b0;
    for (cyc = 0; cyc < 10; cyc++) begin
      #1;
      if (busy && !vec_ready) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_checks++; if (!seen) begin n_errors++; $display("FAIL abort_reach_capture: got no capture in 10 cycles exp capture"); end
    @(negedge clk);
    abort = 1'b1;
    #1;
    n_checks++; if (scan_clk_en !== 1'b1 || scan_en !== 1'b0) begin n_errors++; $display("FAIL abort_in_capture: got clk_en=%b en=%b exp 1 0", scan_clk_en, scan_en); end
    @(negedge clk);
    abort = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || scan_en !== 1'b0 || done !== 1'b0) begin n_errors++; $display("FAIL abort_idle: got busy=%b en=%b done=%b exp 0 0 0", busy, scan_en, done); end
    n_checks++; if (pattern_number !== 16'd0 || vector_number !== 8'd0) begin n_errors++; $display("FAIL abort_hold: got pat=%0d vec=%0d exp 0 0", pattern_number, vector_number); end
    dones = 0;
    repeat (4) begin
      @(negedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    n_checks++; if (dones !== 0) begin n_errors++; $display("FAIL abort_no_done: got %0d active cycles exp 0", dones); end
    vec_valid = 1'b0;
  endtask

  task automatic test_saturate;
    fill_tables(25);
    for (int i = 0; i < 25; i++) flip_tab[i] = 4'b1001;
    model(5, 4, 4);
    drive_run(5, 4, 0);
    n_checks++; if (timed_out || n_done !== 1) begin n_errors++; $display("FAIL sat_done: got %0d done pulses exp 1", n_done); end
    n_checks++; if (miscmp_cnt4 !== 4'(exp_mis)) begin n_errors++; $display("FAIL sat_count4: got %0d exp %0d", miscmp_cnt4, exp_mis); end
    n_checks++; if (fail4 !== 1'b1 || first_fail_pat4 !== 4'(exp_ffp)) begin n_errors++; $display("FAIL sat_first4: got fail=%b first=%0d exp 1 %0d", fail4, first_fail_pat4, exp_ffp); end
    model(5, 4, PATW);
    n_checks++; if (miscmp_cnt !== PATW'(exp_mis)) begin n_errors++; $display("FAIL sat_count16: got %0d exp %0d", miscmp_cnt, exp_mis); end
  endtask

  task automatic test_zero_cfg(input int len, input int npat);
    @(negedge clk);
    cfg_len = LENW'(len); cfg_npat = PATW'(npat); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    n_checks++; if (done !== 1'b1 || busy !== 1'b1 || vec_ready !== 1'b0) begin n_errors++; $display("FAIL zero_%0d_%0d_done: got done=%b busy=%b ready=%b exp 1 1 0", len, npat, done, busy, vec_ready); end
    @(negedge clk); #1;
    n_checks++; if (done !== 1'b0 || busy !== 1'b0 || fail !== 1'b0 || miscmp_cnt !== '0) begin n_errors++; $display("FAIL zero_%0d_%0d_after: got done=%b busy=%b fail=%b cnt=%0d exp 0 0 0 0", len, npat, done, busy, fail, miscmp_cnt); end
  endtask

  task automatic test_start_abort;
    @(negedge clk);
    cfg_len = 8'd3; cfg_npat = 16'd2; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_errors++; $display("FAIL start_abort: got busy=%b done=%b exp 0 0", busy, done); end
  endtask

  task automatic test_random;
    int len, npat, cap, total;
    for (int r = 0; r < 8; r++) begin
      len  = $urandom_range(1, 6);
      npat = $urandom_range(1, 4);
      cap  = $urandom_range(0, 3);
      total = (npat + 1) * len;
      fill_tables(total);
      for (int i = 0; i < total; i++) begin
        if ($urandom_range(0, 3) == 0) flip_tab[i] = NCHAIN'($urandom);
        if ($urandom_range(0, 2) == 0) msk_tab[i]  = NCHAIN'($urandom);
        gap_tab[i] = $urandom_range(0, 2);
      end
      model(len, npat, PATW);
      drive_run(len, npat, cap);
      n_checks++; if (timed_out || n_done !== 1 || n_acc !== total) begin n_errors++; $display("FAIL rand%0d_flow: got %0d vectors %0d done exp %0d 1", r, n_acc, n_done, total); end
      n_checks++; if (cap_pulses !== npat || cap_cycles !== npat * (cap + 1)) begin n_errors++; $display("FAIL rand%0d_capture: got %0d pulses %0d cycles exp %0d %0d", r, cap_pulses, cap_cycles, npat, npat * (cap + 1)); end
      n_checks++; if (si_bad !== 0 || vn_bad !== 0 || stall_bad !== 0) begin n_errors++; $display("FAIL rand%0d_stream: got si=%0d pos=%0d stall=%0d exp 0 0 0", r, si_bad, vn_bad, stall_bad); end
      n_checks++; if (miscmp_cnt !== PATW'(exp_mis) || fail !== exp_fail || first_fail_pat !== PATW'(exp_ffp)) begin n_errors++; $display("FAIL rand%0d_result: got cnt=%0d fail=%b first=%0d exp %0d %b %0d", r, miscmp_cnt, fail, first_fail_pat, exp_mis, exp_fail, exp_ffp); end
    end
  endtask

  task automatic test_reset_midrun;
    @(negedge clk);
    cfg_len = 8'd4; cfg_npat = 16'd3; cfg_cap = 2'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; vec_valid = 1'b1; vec_exp = 4'h0; vec_msk = '0; scan_so = 4'hF;
    repeat (7) @(negedge clk);
    srst = 1'b1; abort = 1'b1;
    @(negedge clk);
    srst = 1'b0; abort = 1'b0; vec_valid = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || fail !== 1'b0 || miscmp_cnt !== '0) begin n_errors++; $display("FAIL midreset_status: got busy=%b fail=%b cnt=%0d exp 0 0 0", busy, fail, miscmp_cnt); end
    n_checks++; if (pattern_number !== '0 || vector_number !== '0 || first_fail_pat !== '0) begin n_errors++; $display("FAIL midreset_counters: got %0d %0d %0d exp 0 0 0", pattern_number, vector_number, first_fail_pat); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mismatch(1'b0);
    test_mismatch(1'b1);
    test_stall();
    test_abort();
    test_saturate();
    test_zero_cfg(0, 2);
    test_zero_cfg(3, 0);
    test_start_abort();
    test_random();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
